// File: rtl/packetizer_pkg.sv
// Shared definitions for the 48-bit flit link framer and de-framer.
// Holds the marker values, the flit field offsets and the framer FSM states.
package packetizer_pkg;

    localparam int unsigned FlitW     = 48;
    localparam int unsigned MarkerW   = 16;
    localparam int unsigned PayloadW  = 16;
    localparam int unsigned PktIdW    = 8;
    localparam int unsigned FlitSeqW  = 8;

    localparam int unsigned MarkerLsb  = 32;
    localparam int unsigned PayloadLsb = 16;
    localparam int unsigned PktIdLsb   = 8;
    localparam int unsigned FlitSeqLsb = 0;

    localparam logic [MarkerW-1:0] MarkerHead = 16'hA5A5;
    localparam logic [MarkerW-1:0] MarkerBody = 16'h0000;
    localparam logic [MarkerW-1:0] MarkerTail = 16'hFFFF;

    typedef logic [FlitW-1:0] flit_t;

    typedef enum logic [1:0] {
        StIdle,
        StHead,
        StPayload
    } pkt_state_e;

    function automatic flit_t make_flit(input logic [MarkerW-1:0]  marker,
                                        input logic [PayloadW-1:0] payload,
                                        input logic [PktIdW-1:0]   pkt_id,
                                        input logic [FlitSeqW-1:0] flit_seq);
        return {marker, payload, pkt_id, flit_seq};
    endfunction

endpackage

// File: rtl/packetizer_if.sv
// Source-word and flit-channel handshake bundle of the packetizer.
// The slave modport is the framer; the master modport is its environment.
interface packetizer_if;
    import packetizer_pkg::*;

    logic [PayloadW-1:0] data_in;
    logic                data_valid;
    logic                data_last;
    logic                data_ready;
    logic [7:0]          dest_id;
    flit_t               flitout;
    logic                flit_valid;
    logic                flit_ready;

    modport master (
        output data_in,
        output data_valid,
        output data_last,
        output dest_id,
        output flit_ready,
        input  data_ready,
        input  flitout,
        input  flit_valid
    );

    modport slave (
        input  data_in,
        input  data_valid,
        input  data_last,
        input  dest_id,
        input  flit_ready,
        output data_ready,
        output flitout,
        output flit_valid
    );

endinterface

// File: rtl/packetizer_flit_out_reg.sv
// 48-bit valid/ready output register slice for the flit channel.
// The owner asserts load_i only when the slot is empty or being drained this cycle.
module packetizer_flit_out_reg
    import packetizer_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load_i,
    input  flit_t data_i,
    input  logic  ready_i,
    output flit_t data_o,
    output logic  valid_o
);

    flit_t data_q, data_d;
    logic  valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/packetizer.sv
// Transmit-side framer: wraps a stream of 16-bit payload words into head, body
// and tail flits, splitting packets that exceed MAX_WORDS words.
module packetizer
    import packetizer_pkg::*;
#(
    parameter logic [7:0]  SRC_ID    = 8'h00,
    parameter int unsigned MAX_WORDS = 16
) (
    input  logic         clk,
    input  logic         reset,
    packetizer_if.slave  bus,
    output logic         busy,
    output logic         len_err
);

    pkt_state_e state_q, state_d;
    logic [PktIdW-1:0]   pkt_id_q, pkt_id_d, pkt_id_cur;
    logic [FlitSeqW-1:0] seq_q, seq_d;
    logic [7:0]          word_cnt_q, word_cnt_d;
    logic                busy_q, busy_d;
    logic                len_err_q, len_err_d;

    logic  reg_free;
    logic  tail_acc;
    logic  data_ready;
    logic  word_acc;
    logic  last_slot;
    logic  load;
    flit_t load_flit;

    always_comb begin
        reg_free   = !bus.flit_valid || bus.flit_ready;
        tail_acc   = bus.flit_valid && bus.flit_ready &&
                     (bus.flitout[MarkerLsb +: MarkerW] == MarkerTail);
        data_ready = (state_q != StIdle) && reg_free;
        word_acc   = bus.data_valid && data_ready;
        last_slot  = ({1'b0, word_cnt_q} + 9'd1) == 9'(MAX_WORDS);
        // A head loaded as the tail leaves must already carry the next packet ID.
        pkt_id_cur = tail_acc ? pkt_id_q + 8'd1 : pkt_id_q;
    end

    always_comb begin
        state_d    = state_q;
        pkt_id_d   = pkt_id_cur;
        seq_d      = seq_q;
        word_cnt_d = word_cnt_q;
        busy_d     = busy_q && !tail_acc;
        len_err_d  = len_err_q;
        load       = 1'b0;
        load_flit  = '0;

        case (state_q)
            StIdle: begin
                if (bus.data_valid && reg_free) begin
                    load       = 1'b1;
                    load_flit  = make_flit(MarkerHead, {bus.dest_id, SRC_ID}, pkt_id_cur, 8'd0);
                    seq_d      = 8'd1;
                    word_cnt_d = 8'd0;
                    busy_d     = 1'b1;
                    state_d    = StHead;
                end
            end
            StHead, StPayload: begin
                // In StHead the register always holds the head, so reg_free means it left.
                if (state_q == StHead && reg_free) begin
                    state_d = StPayload;
                end
                if (word_acc) begin
                    load       = 1'b1;
                    seq_d      = seq_q + 8'd1;
                    word_cnt_d = word_cnt_q + 8'd1;
                    if (bus.data_last || last_slot) begin
                        load_flit = make_flit(MarkerTail, bus.data_in, pkt_id_cur, seq_q);
                        state_d   = StIdle;
                        if (!bus.data_last) begin
                            len_err_d = 1'b1;
                        end
                    end else begin
                        load_flit = make_flit(MarkerBody, bus.data_in, pkt_id_cur, seq_q);
                        state_d   = StPayload;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            pkt_id_q   <= '0;
            seq_q      <= '0;
            word_cnt_q <= '0;
            busy_q     <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pkt_id_q   <= pkt_id_d;
            seq_q      <= seq_d;
            word_cnt_q <= word_cnt_d;
            busy_q     <= busy_d;
            len_err_q  <= len_err_d;
        end
    end

    packetizer_flit_out_reg u_out_reg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .data_i  (load_flit),
        .ready_i (bus.flit_ready),
        .data_o  (bus.flitout),
        .valid_o (bus.flit_valid)
    );

    assign bus.data_ready = data_ready;
    assign busy           = busy_q;
    assign len_err        = len_err_q;

endmodule

// File: tb/tb_packetizer.sv
// Scoreboard bench for the packetizer: expected flits are queued as words are
// issued and a monitor pops them on every accepted flit.
module tb_packetizer;
    import packetizer_pkg::*;

    localparam logic [7:0]  Src  = 8'h34;
    localparam int unsigned MaxW = 16;

    logic clk = 1'b0;
    logic reset;
    logic busy, len_err;

    always #5 clk = ~clk;

    packetizer_if bus ();

    packetizer #(
        .SRC_ID    (Src),
        .MAX_WORDS (MaxW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .busy    (busy),
        .len_err (len_err)
    );

    int    n_vec = 0;
    int    n_err = 0;
    flit_t exp_q[$];
    logic [7:0] exp_pid;
    bit    mon_en;
    bit    gap_chk;
    bit    last_was_tail;
    bit    stalled;
    flit_t held;
    int    cyc = 0;
    int    last_acc_cyc = 0;
    int    busy_cnt = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Model: split into MaxW-word chunks, each with a head and a tail.
    task automatic push_packet(input logic [7:0] dest, input logic [15:0] words[$]);
        int i = 0;
        while (i < words.size()) begin
            int chunk = (words.size() - i > MaxW) ? MaxW : words.size() - i;
            exp_q.push_back({MarkerHead, dest, Src, exp_pid, 8'd0});
            for (int j = 0; j < chunk; j++) begin
                exp_q.push_back({(j == chunk - 1) ? MarkerTail : MarkerBody, words[i + j],
                                 exp_pid, 8'(j + 1)});
            end
            exp_pid++;
            i += chunk;
        end
    endtask

    // Entered just after a rising edge; returns just after the accepting edge.
    task automatic send_word(input logic [15:0] w, input logic last);
        int t = 0;
        bus.data_in    = w;
        bus.data_last  = last;
        bus.data_valid = 1'b1;
        @(negedge clk);
        while (!bus.data_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (t >= 200) fail("accept_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic send_words(input logic [15:0] words[$]);
        for (int i = 0; i < words.size(); i++) begin
            send_word(words[i], i == words.size() - 1);
        end
        bus.data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) fail("idle_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cnt++;
            if (mon_en && !reset) begin
                if (stalled && bus.flit_valid) check("hold_flit", bus.flitout, held);
                if (bus.flit_valid && !bus.flit_ready) begin
                    check("ready_in_stall", 48'(bus.data_ready), 48'd0);
                    stalled = 1'b1;
                    held    = bus.flitout;
                end else begin
                    stalled = 1'b0;
                end
                if (bus.flit_valid && bus.flit_ready) begin
                    if (exp_q.size() == 0) begin
                        fail("unexpected_flit");
                    end else begin
                        check("flit", bus.flitout, exp_q.pop_front());
                    end
                    if (gap_chk && last_was_tail && bus.flitout[47:32] == MarkerHead) begin
                        check("tail_head_gap", 48'(cyc - last_acc_cyc), 48'd1);
                    end
                    last_was_tail = (bus.flitout[47:32] == MarkerTail);
                    last_acc_cyc  = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [15:0] words[$];
        reset          = 1'b1;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.data_last  = 1'b0;
        bus.dest_id    = '0;
        bus.flit_ready = 1'b1;
        mon_en         = 1'b1;
        gap_chk        = 1'b0;
        last_was_tail  = 1'b0;
        stalled        = 1'b0;
        exp_pid        = 8'd0;

        #12;
        check("rst_flitout", bus.flitout, 48'd0);
        check("rst_flit_valid", 48'(bus.flit_valid), 48'd0);
        check("rst_data_ready", 48'(bus.data_ready), 48'd0);
        check("rst_busy", 48'(busy), 48'd0);
        check("rst_len_err", 48'(len_err), 48'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 3-word packet, hand-computed flits
        busy_cnt    = 0;
        bus.dest_id = 8'h12;
        exp_q.push_back(48'hA5A5_1234_0000);
        exp_q.push_back(48'h0000_1111_0001);
        exp_q.push_back(48'h0000_2222_0002);
        exp_q.push_back(48'hFFFF_3333_0003);
        exp_pid = 8'd1;
        words   = '{16'h1111, 16'h2222, 16'h3333};
        send_words(words);
        wait_idle();
        check("busy_cycles", 48'(busy_cnt), 48'd4);

        // single-word packet, pkt_id now 1
        bus.dest_id = 8'h56;
        exp_q.push_back(48'hA5A5_5634_0100);
        exp_q.push_back(48'hFFFF_BEEF_0101);
        exp_pid = 8'd2;
        words   = '{16'hBEEF};
        send_words(words);
        wait_idle();
        check("len_err_clean", 48'(len_err), 48'd0);

        // downstream stall of 3 cycles in the middle of the body
        bus.dest_id = 8'h9A;
        words       = '{16'hC000, 16'hC001, 16'hC002, 16'hC003, 16'hC004};
        push_packet(8'h9A, words);
        fork
            send_words(words);
            begin
                repeat (3) @(posedge clk);
                #1 bus.flit_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.flit_ready = 1'b1;
            end
        join
        wait_idle();

        // 20 words with MaxW = 16: truncated tail then a fresh packet
        bus.dest_id = 8'h77;
        words       = {};
        for (int i = 0; i < 20; i++) words.push_back(16'h7000 + 16'(i));
        push_packet(8'h77, words);
        send_words(words);
        wait_idle();
        check("len_err_set", 48'(len_err), 48'd1);

        // 256 back-to-back single-word packets: pkt_id wraps, no bubbles
        bus.dest_id   = 8'h3C;
        last_was_tail = 1'b0;
        gap_chk       = 1'b1;
        for (int k = 0; k < 256; k++) begin
            words = '{16'h5A00 ^ 16'(k)};
            push_packet(8'h3C, words);
            send_word(words[0], 1'b1);
        end
        bus.data_valid = 1'b0;
        wait_idle();
        gap_chk = 1'b0;
        check("pid_model_wrapped", 48'(exp_pid), 48'd5);

        // reset in the middle of a body flit stream
        mon_en         = 1'b0;
        bus.dest_id    = 8'h21;
        bus.data_in    = 16'hAAAA;
        bus.data_last  = 1'b0;
        bus.data_valid = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("pre_reset_valid", 48'(bus.flit_valid), 48'd1);
        check("pre_reset_busy", 48'(busy), 48'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_flitout", bus.flitout, 48'd0);
        check("mid_rst_flit_valid", 48'(bus.flit_valid), 48'd0);
        check("mid_rst_data_ready", 48'(bus.data_ready), 48'd0);
        check("mid_rst_busy", 48'(busy), 48'd0);
        check("mid_rst_len_err", 48'(len_err), 48'd0);
        bus.data_valid = 1'b0;
        exp_q.delete();
        exp_pid = 8'd0;
        @(posedge clk);
        #1;
        reset         = 1'b0;
        last_was_tail = 1'b0;
        stalled       = 1'b0;
        mon_en        = 1'b1;

        // first packet after reset restarts pkt_id and flit_seq
        bus.dest_id = 8'h42;
        exp_q.push_back(48'hA5A5_4234_0000);
        exp_q.push_back(48'hFFFF_1234_0001);
        exp_pid = 8'd1;
        words   = '{16'h1234};
        send_words(words);
        wait_idle();

        check("queue_drained", 48'(exp_q.size()), 48'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/packetizer.md
# packetizer

Transmit-side framer for the 48-bit flit link: accepts a stream of 16-bit payload words with a last-word marker and emits one head flit followed by body flits and a tail flit per packet. Sits between the source data path and the NoC flit channel, directly upstream of the de-packetizer, which recovers payload from flit bits [31:16] and detects packet end by marker 16'hFFFF in bits [47:32].

## Interface
- SRC_ID, 8'h00, source node ID placed in every head flit
- MAX_WORDS, 16, max payload words per packet (1..255); word MAX_WORDS is forced to tail
- clk  in  1  main clock, rising edge
- reset  in  1  asynchronous, active-high reset
- data_in  in  16  payload word
- data_valid  in  1  data_in/data_last valid
- data_last  in  1  final word of packet
- data_ready  out  1  word accepted when data_valid && data_ready
- dest_id  in  8  destination ID; sampled when head flit is issued
- flitout  out  48  flit: [47:32] marker, [31:16] payload/route, [15:0] {pkt_id, flit_seq}
- flit_valid  out  1  flitout valid
- flit_ready  in  1  downstream accepts when flit_valid && flit_ready
- busy  out  1  high from head issue until tail accepted
- len_err  out  1  sticky; set when a packet is truncated at MAX_WORDS

## Operation
- Markers: HEAD 16'hA5A5, BODY 16'h0000, TAIL 16'hFFFF. Payload words never use marker field.
- Head flit: [31:16]={dest_id, SRC_ID}; body/tail: [31:16]=data_in.
- [15:8]=pkt_id (8-bit, +1 per tail accepted, wraps 255->0); [7:0]=flit_seq (head=0, +1 per flit, restarts at 0 each packet).
- FSM IDLE -> HEAD -> PAYLOAD -> IDLE:
  - IDLE: data_ready=0. If data_valid, load head flit into output register, go HEAD. Word is not consumed.
  - HEAD: hold head until accepted; then PAYLOAD.
  - PAYLOAD: data_ready = !flit_valid || flit_ready. Each accepted word loads one flit: TAIL if data_last or word count == MAX_WORDS, else BODY. After loading tail, go IDLE once tail accepted (IDLE may load next head in same cycle the tail leaves).
- Truncation: word MAX_WORDS without data_last is emitted as TAIL, len_err set; remaining words form a new packet with a fresh head.
- Single-word packet: head, then tail carrying the word.
- Output register holds flitout stable while flit_valid && !flit_ready (no change, no drop).
- reset: state IDLE, flitout=0, flit_valid=0, data_ready=0, busy=0, len_err=0, pkt_id=0, flit_seq=0. Reset mid-packet discards the packet; no tail emitted.

## Timing
- Head flit valid 1 cycle after data_valid seen in IDLE with output register free.
- First payload word accepted earliest in the cycle head is accepted; its flit valid next cycle.
- Full throughput: one flit per cycle with flit_ready held high; packet of N words occupies N+1 flit cycles.
- Back-to-back packets: next head may be loaded in the cycle the previous tail is accepted (no bubble).
- data_ready combinationally depends on flit_ready only (no path from data_valid).
- busy falls the cycle after tail acceptance.

## Structure
- Shared package/header: marker constants (HEAD/BODY/TAIL), field offsets for marker/payload/pkt_id/flit_seq, FSM state encoding; shared with the de-packetizer.
- One natural sub-module: flit_out_reg, a 48-bit valid/ready output register slice; FSM and counters live in packetizer.

## Test plan
- 3-word packet, dest_id=8'h12, SRC_ID=8'h34, flit_ready=1 -> flits A5A5_1234_0000, 0000_w0_0001, 0000_w1_0002, FFFF_w2_0003; busy high 4 cycles.
- Single word 16'hBEEF with data_last -> A5A5_{dest,src}_0000 then FFFF_BEEF_0001; pkt_id then 1.
- flit_ready low 3 cycles mid-body -> flitout stable, data_ready low, no word lost or duplicated.
- 20-word packet, MAX_WORDS=16 -> tail at word 16, len_err=1, words 17-20 in new packet with pkt_id+1 and fresh head.
- 256 back-to-back 1-word packets -> pkt_id wraps 255->0, no idle cycle between tail and next head.
- reset asserted during body flit -> all outputs zero immediately; next packet starts with pkt_id=0, flit_seq=0.
